// File: rtl/response_tag_tracker_pkg.sv
// Shared types for the response tag tracker: command metadata, PSL response
// bundle, response codes and the tracker FSM states.
package response_tag_tracker_pkg;

    localparam int MAX_TAG_WIDTH = 8;

    // PSL response codes; any other value is still retired normally.
    typedef enum logic [7:0] {
        RESP_DONE    = 8'h00,
        RESP_AERROR  = 8'h01,
        RESP_DERROR  = 8'h03,
        RESP_NLOCK   = 8'h04,
        RESP_NRES    = 8'h05,
        RESP_FLUSHED = 8'h06,
        RESP_FAULT   = 8'h07,
        RESP_FAILED  = 8'h08,
        RESP_PAGED   = 8'h0A
    } response_code_e;

    // Metadata remembered against each granted tag.
    typedef struct packed {
        logic [7:0]  cu_id;
        logic [7:0]  cmd_type;
        logic [15:0] cacheline_index;
    } command_tag_line_t;

    // Raw PSL response as seen on the response bus.
    typedef struct packed {
        logic                     valid;
        logic [MAX_TAG_WIDTH-1:0] tag;
        logic [7:0]               response;
    } response_interface_t;

    typedef enum logic {
        TT_INIT  = 1'b0,
        TT_READY = 1'b1
    } tag_tracker_state_e;

endpackage

// File: rtl/tag_free_list_fifo.sv
// Synchronous FIFO holding the free tag numbers. Push and pop may happen in
// the same cycle; the head is visible combinationally.
module tag_free_list_fifo #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [ADDR_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_W);
    assign head    = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A pop frees the slot being written, so a push into a full FIFO is fine then.
    assign do_push = push && (!full || do_pop);

    // Storage write; contents need no reset because count_q guards every read.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/response_tag_tracker.sv
// Hands out CAPI command tags from a free list, remembers per-tag metadata and
// retires tags when their PSL response returns.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// TT_INIT  | filling the free list with tags 0..TAG_COUNT-1, no grants
// TT_READY | normal operation: grant on request, retire on response
module response_tag_tracker
    import response_tag_tracker_pkg::*;
#(
    parameter int TAG_COUNT = 256,
    parameter int TAG_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enabled_in,
    input  logic                  cmd_tag_req,
    input  command_tag_line_t     cmd_tag_line_in,
    output logic                  cmd_tag_ready,
    output logic [TAG_WIDTH-1:0]  cmd_tag_out,
    input  response_interface_t   response,
    output response_interface_t   response_out,
    output command_tag_line_t     response_tag_id_out,
    output logic [TAG_WIDTH:0]    tags_in_flight,
    output logic                  tag_error
);

    localparam logic [TAG_WIDTH:0] TAG_COUNT_W = (TAG_WIDTH+1)'(TAG_COUNT);

    tag_tracker_state_e  state_q;
    tag_tracker_state_e  state_d;
    logic [TAG_WIDTH:0]  init_count_q;
    logic [TAG_COUNT-1:0] outstanding_q;
    command_tag_line_t   tag_table [TAG_COUNT];
    logic [TAG_WIDTH:0]  in_flight_q;
    logic                tag_error_q;
    response_interface_t response_q;
    command_tag_line_t   tag_line_q;

    logic                fl_push;
    logic                fl_pop;
    logic [TAG_WIDTH-1:0] fl_push_data;
    logic [TAG_WIDTH-1:0] fl_head;
    logic                fl_empty;
    logic                fl_full;

    logic                init_pushing;
    logic                alloc;
    logic                retire;
    logic                resp_in_range;
    logic [TAG_WIDTH-1:0] resp_idx;

    assign init_pushing  = (state_q == TT_INIT) && (init_count_q < TAG_COUNT_W);
    assign cmd_tag_ready = (state_q == TT_READY) && enabled_in && !fl_empty;
    assign cmd_tag_out   = cmd_tag_ready ? fl_head : '0;
    assign alloc         = cmd_tag_req && cmd_tag_ready;

    // Tags beyond TAG_COUNT can never be outstanding and are reported as errors.
    assign resp_in_range = ((response.tag >> TAG_WIDTH) == '0);
    assign resp_idx      = response.tag[TAG_WIDTH-1:0];
    assign retire        = response.valid && resp_in_range && outstanding_q[resp_idx];

    // Retired tags go to the tail, so they cannot be regranted in the same cycle.
    assign fl_push       = (init_pushing || retire) && !fl_full;
    assign fl_push_data  = init_pushing ? init_count_q[TAG_WIDTH-1:0] : resp_idx;
    assign fl_pop        = alloc;

    tag_free_list_fifo #(
        .DEPTH      (TAG_COUNT),
        .ADDR_WIDTH (TAG_WIDTH)
    ) u_free_list (
        .clock     (clock),
        .reset     (reset),
        .push      (fl_push),
        .push_data (fl_push_data),
        .pop       (fl_pop),
        .head      (fl_head),
        .empty     (fl_empty),
        .full      (fl_full)
    );

    // FSM state register and init tag counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= TT_INIT;
            init_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (init_pushing) begin
                init_count_q <= init_count_q + (TAG_WIDTH+1)'(1);
            end
        end
    end

    // Next-state: leave INIT the cycle after the last tag has been pushed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TT_INIT:  if (init_count_q == TAG_COUNT_W) state_d = TT_READY;
            TT_READY: state_d = TT_READY;
            default:  state_d = TT_INIT;
        endcase
    end

    // Outstanding bitmap: set on grant, cleared on legal retirement.
    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding_q <= '0;
        end else begin
            if (alloc) begin
                outstanding_q[fl_head] <= 1'b1;
            end
            if (retire) begin
                outstanding_q[resp_idx] <= 1'b0;
            end
        end
    end

    // Metadata table, written at grant time; stale entries are never exposed.
    always_ff @(posedge clock) begin
        if (alloc) begin
            tag_table[fl_head] <= cmd_tag_line_in;
        end
    end

    // Response pipeline stage with its metadata lookup and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            response_q  <= '0;
            tag_line_q  <= '0;
            tag_error_q <= 1'b0;
        end else begin
            response_q  <= response.valid ? response : '0;
            tag_line_q  <= retire ? tag_table[resp_idx] : '0;
            tag_error_q <= tag_error_q || (response.valid && !retire);
        end
    end

    // Outstanding tag counter; a simultaneous grant and retirement cancel out.
    always_ff @(posedge clock) begin
        if (reset) begin
            in_flight_q <= '0;
        end else if (alloc && !retire && (in_flight_q != TAG_COUNT_W)) begin
            in_flight_q <= in_flight_q + (TAG_WIDTH+1)'(1);
        end else if (!alloc && retire && (in_flight_q != '0)) begin
            in_flight_q <= in_flight_q - (TAG_WIDTH+1)'(1);
        end
    end

    assign response_out        = response_q;
    assign response_tag_id_out = tag_line_q;
    assign tags_in_flight      = in_flight_q;
    assign tag_error           = tag_error_q;

endmodule

// File: tb/tb_response_tag_tracker.sv
// Scoreboard bench for response_tag_tracker: directed scenarios followed by
// randomized traffic against a queue-based reference model.
module tb_response_tag_tracker;
    import response_tag_tracker_pkg::*;

    localparam int TC = 256;
    localparam int TW = 8;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                enabled_in = 1'b0;
    logic                cmd_tag_req = 1'b0;
    command_tag_line_t   cmd_tag_line_in = '0;
    logic                cmd_tag_ready;
    logic [TW-1:0]       cmd_tag_out;
    response_interface_t response = '0;
    response_interface_t response_out;
    command_tag_line_t   response_tag_id_out;
    logic [TW:0]         tags_in_flight;
    logic                tag_error;

    response_tag_tracker #(.TAG_COUNT(TC), .TAG_WIDTH(TW)) dut (
        .clock               (clock),
        .reset               (reset),
        .enabled_in          (enabled_in),
        .cmd_tag_req         (cmd_tag_req),
        .cmd_tag_line_in     (cmd_tag_line_in),
        .cmd_tag_ready       (cmd_tag_ready),
        .cmd_tag_out         (cmd_tag_out),
        .response            (response),
        .response_out        (response_out),
        .response_tag_id_out (response_tag_id_out),
        .tags_in_flight      (tags_in_flight),
        .tag_error           (tag_error)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        response_interface_t r;
        command_tag_line_t   l;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: free tags in grant order, outstanding set, metadata.
    int                free_q[$];
    int                out_q[$];
    bit                m_out [TC];
    command_tag_line_t m_table [TC];
    int                m_in_flight;
    bit                m_err;
    int                cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: consume one scoreboard entry per presented response.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (response_out.valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got tag %0h expected none", response_out.tag);
                end else begin
                    e = sb_q.pop_front();
                    chk("response_out", 64'(response_out), 64'(e.r));
                    chk("response_tag_id_out", 64'(response_tag_id_out), 64'(e.l));
                end
            end else begin
                chk("idle_tag_id_out", 64'(response_tag_id_out), 64'(0));
            end
        end
    end

    task automatic do_reset();
        reset       = 1'b1;
        cmd_tag_req = 1'b0;
        enabled_in  = 1'b1;
        response    = '0;
        @(posedge clock);
        #1;
        chk("rst_cmd_tag_ready", 64'(cmd_tag_ready), 64'(0));
        chk("rst_cmd_tag_out", 64'(cmd_tag_out), 64'(0));
        chk("rst_response_out", 64'(response_out), 64'(0));
        chk("rst_tag_id_out", 64'(response_tag_id_out), 64'(0));
        chk("rst_tags_in_flight", 64'(tags_in_flight), 64'(0));
        chk("rst_tag_error", 64'(tag_error), 64'(0));
        reset = 1'b0;
        free_q.delete();
        out_q.delete();
        for (int i = 0; i < TC; i++) begin
            free_q.push_back(i);
            m_out[i] = 1'b0;
        end
        m_in_flight = 0;
        m_err       = 1'b0;
        cyc         = 0;
    endtask

    // One clock of stimulus; granted is the tag the model expects handed out, or -1.
    task automatic step(input bit req, input bit en, input bit rv,
                        input logic [7:0] rtag, input logic [7:0] rcode,
                        output int granted);
        command_tag_line_t line;
        bit   exp_ready;
        bit   alloc;
        bit   retire;
        exp_t e;
        int   idx[$];
        line = command_tag_line_t'($urandom);
        cmd_tag_req       = req;
        enabled_in        = en;
        cmd_tag_line_in   = line;
        response.valid    = rv;
        response.tag      = rtag;
        response.response = rcode;
        #1;
        exp_ready = (cyc >= TC + 1) && en && (free_q.size() > 0);
        chk("cmd_tag_ready", 64'(cmd_tag_ready), 64'(exp_ready));
        if (exp_ready) chk("cmd_tag_out", 64'(cmd_tag_out), 64'(free_q[0]));
        alloc   = req && exp_ready;
        retire  = rv && m_out[rtag];
        granted = -1;
        if (alloc && rv)
            chk("no_same_tag_alloc_retire", 64'(cmd_tag_out == rtag && m_out[rtag]), 64'(0));
        if (rv) begin
            e.r = '{valid: 1'b1, tag: rtag, response: rcode};
            e.l = retire ? m_table[rtag] : '0;
            sb_q.push_back(e);
        end
        if (alloc) begin
            granted = free_q.pop_front();
            m_out[granted]   = 1'b1;
            m_table[granted] = line;
            out_q.push_back(granted);
            m_in_flight++;
        end
        if (retire) begin
            m_out[rtag] = 1'b0;
            free_q.push_back(int'(rtag));
            idx = out_q.find_first_index(x) with (x == int'(rtag));
            if (idx.size() > 0) out_q.delete(idx[0]);
            m_in_flight--;
        end else if (rv) begin
            m_err = 1'b1;
        end
        @(posedge clock);
        #1;
        cyc++;
        chk("tags_in_flight", 64'(tags_in_flight), 64'(m_in_flight));
        chk("tag_error", 64'(tag_error), 64'(m_err));
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, g);
    endtask

    initial begin : main
        int g;
        bit rq, en, rv;
        logic [7:0] rtag;
        logic [7:0] codes [10];
        codes = '{8'h00, 8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h55};

        // Init: ready must come up exactly TC+1 cycles after reset drops.
        do_reset();
        idle(TC + 3);

        // Three grants, retire tag 1, then tag 1 comes back only after 3..255.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, g);
            chk("first_grants", 64'(g), 64'(i));
        end
        step(1'b0, 1'b1, 1'b1, 8'd1, RESP_DONE, g);
        for (int i = 0; i < TC - 2; i++) step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, g);
        chk("tag1_regranted_last", 64'(g), 64'(1));

        // Full: request ignored; a PAGED retirement makes tag 7 grantable.
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, g);
        chk("full_no_grant", 64'(g), 64'(-1));
        chk("full_in_flight", 64'(tags_in_flight), 64'(TC));
        step(1'b0, 1'b1, 1'b1, 8'd7, RESP_PAGED, g);
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, g);
        chk("regrant_7", 64'(g), 64'(7));

        // Same-cycle grant of 20 with FLUSHED retirement of 30.
        step(1'b0, 1'b1, 1'b1, 8'd20, RESP_FLUSHED, g);
        step(1'b1, 1'b1, 1'b1, 8'd30, RESP_FLUSHED, g);
        chk("same_cycle_grant", 64'(g), 64'(20));
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, g);
        chk("grant_after_same_cycle", 64'(g), 64'(30));

        // Retirement still happens while allocation is disabled.
        step(1'b0, 1'b0, 1'b1, 8'd40, RESP_AERROR, g);
        step(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, g);
        chk("disabled_no_grant", 64'(g), 64'(-1));
        step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, g);
        chk("grant_40", 64'(g), 64'(40));

        // Response for a never-allocated tag sets a sticky error.
        do_reset();
        idle(TC + 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, g);
        step(1'b0, 1'b1, 1'b1, 8'd9, RESP_DONE, g);
        idle(3);

        // Reset with 10 outstanding, response during INIT and after re-init.
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 8'd0, 8'd0, g);
        chk("ten_outstanding", 64'(tags_in_flight), 64'(10));
        do_reset();
        step(1'b0, 1'b1, 1'b1, 8'd2, RESP_DONE, g);
        do_reset();
        idle(TC + 1);
        step(1'b0, 1'b1, 1'b1, 8'd4, RESP_DONE, g);
        chk("old_tag_error", 64'(tag_error), 64'(1));

        // Randomized traffic across all response codes.
        do_reset();
        idle(TC + 1);
        for (int n = 0; n < 2500; n++) begin
            rq = ($urandom_range(0, 99) < 60);
            en = ($urandom_range(0, 99) < 85);
            rv = ($urandom_range(0, 99) < 50);
            if (out_q.size() > 0 && $urandom_range(0, 19) != 0)
                rtag = 8'(out_q[$urandom_range(0, out_q.size() - 1)]);
            else
                rtag = 8'($urandom_range(0, TC - 1));
            step(rq, en, rv, rtag, codes[$urandom_range(0, 9)], g);
        end
        idle(3);
        chk("scoreboard_drained", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/response_tag_tracker.md
RESPONSE_TAG_TRACKER -- requirements
Module: response_tag_tracker

Interface
REQ-001 SHALL have parameter TAG_COUNT, default 256, number of CAPI command tags managed (power of two, 2..256).
REQ-002 SHALL have parameter TAG_WIDTH, default 8, log2(TAG_COUNT).
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state changes on the rising edge of clock.
REQ-004 SHALL have ports:
- clock  in  1  clock
- reset  in  1  synchronous active-high reset
- enabled_in  in  1  allocation enable
- cmd_tag_req  in  1  requester pops a tag this cycle
- cmd_tag_line_in  in  CommandTagLine  metadata stored against the granted tag
- cmd_tag_ready  out  1  a free tag is available and allocation is permitted
- cmd_tag_out  out  TAG_WIDTH  tag granted when cmd_tag_req && cmd_tag_ready
- response  in  ResponseInterface  raw PSL response (valid, tag, response code)
- response_out  out  ResponseInterface  response delayed one cycle
- response_tag_id_out  out  CommandTagLine  stored metadata for response_out.tag
- tags_in_flight  out  TAG_WIDTH+1  outstanding tag count
- tag_error  out  1  sticky: response for a non-outstanding tag

Function
REQ-005 SHALL implement a two-state FSM, INIT and READY; reset enters INIT.
REQ-006 In INIT, SHALL push tags 0..TAG_COUNT-1 into the free list one per cycle, then enter READY on the cycle after tag TAG_COUNT-1 is pushed (TAG_COUNT+1 cycles after reset deassertion).
REQ-007 cmd_tag_ready SHALL equal (state==READY) && enabled_in && free list not empty.
REQ-008 cmd_tag_out SHALL present the free-list head combinationally whenever cmd_tag_ready is 1.
REQ-009 On cmd_tag_req && cmd_tag_ready, SHALL pop the head, write cmd_tag_line_in to the tag table at that tag, and set its outstanding bit.
REQ-010 cmd_tag_req while cmd_tag_ready is 0 SHALL be ignored, with no state change.
REQ-011 On response.valid with the outstanding bit set for response.tag, SHALL clear the bit and push the tag onto the free-list tail.
REQ-012 Response retirement SHALL occur regardless of enabled_in and for every response code (DONE, FLUSHED, PAGED, AERROR, DERROR, FAILED, FAULT, NRES, NLOCK, other).
REQ-013 response_out SHALL equal response registered one cycle; it is 0 when response.valid was 0.
REQ-014 response_tag_id_out SHALL be the table entry read in the cycle of response.valid and presented with response_out, giving one-cycle latency aligned to response_out.
REQ-015 On response.valid for a non-outstanding tag, SHALL set tag_error, leave the free list and bitmap unchanged, forward response_out normally, and drive response_tag_id_out = 0.
REQ-016 A same-cycle allocation and retirement SHALL both take effect; tags_in_flight is unchanged.
REQ-017 A tag retired in cycle N SHALL not be grantable before cycle N+1; there is no free-list bypass.
REQ-018 A same-cycle allocation and retirement of the same tag is impossible by construction; the bench SHALL assert it never occurs.
REQ-019 tags_in_flight SHALL increment on allocation and decrement on legal retirement, saturating at 0 and TAG_COUNT.
REQ-020 When the free list is empty, cmd_tag_ready SHALL be 0 and tags_in_flight SHALL equal TAG_COUNT.

Reset
REQ-021 Reset SHALL clear: FSM to INIT, free list empty, outstanding bitmap, tags_in_flight, tag_error, response_out, response_tag_id_out, and cmd_tag_ready. The tag table contents need not be cleared.
REQ-022 Reset mid-operation SHALL discard all outstanding tags.
REQ-023 Responses arriving during INIT SHALL be treated per REQ-015.

Structure
REQ-024 CommandTagLine and ResponseInterface SHALL come from the existing CAPI_PKG/CU_PKG.
REQ-025 The new TagTrackerState enum (INIT, READY) SHALL be added to AFU_PKG.
REQ-026 The free list SHALL be a sub-module tag_free_list_fifo: synchronous FIFO, depth TAG_COUNT, simultaneous push/pop, empty and full flags.

Verification
REQ-027 Reset, then idle: cmd_tag_ready rises exactly 257 cycles after reset drops; tags_in_flight=0.
REQ-028 Allocate 3 tags (receiving 0, 1, 2), then a DONE response for tag 1: next cycle response_out.tag=1 with response_tag_id_out equal to the tag-1 line; tags_in_flight goes 3->2; tag 1 is regranted only after tags 3..255.
REQ-029 Allocate all 256 tags: cmd_tag_ready=0 and tags_in_flight=256; one PAGED response for tag 7 -> cmd_tag_ready=1 next cycle and cmd_tag_out=7.
REQ-030 Same-cycle allocation and a FLUSHED retirement of a different tag -> tags_in_flight unchanged; both tags handled correctly.
REQ-031 Response for tag 9 never allocated -> tag_error=1 (sticky), response_tag_id_out=0, tags_in_flight unchanged.
REQ-032 Reset asserted with 10 tags outstanding -> all outputs 0 the next cycle; re-INIT completes; a response for an old tag sets tag_error.
